// File: rtl/mem_ctrl_pkg.sv
// Shared bus widths, request-size codes and FSM encodings for the memory controller.
package mem_ctrl_pkg;

    localparam int unsigned InstAddrW = 32;
    localparam int unsigned InstW     = 32;
    localparam int unsigned RamDataW  = 8;

    localparam logic [1:0] CnfNone = 2'd0;
    localparam logic [1:0] CnfByte = 2'd1;
    localparam logic [1:0] CnfHalf = 2'd2;
    localparam logic [1:0] CnfWord = 2'd3;

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StMemBusy = 2'd1;
    localparam logic [1:0] StIfBusy  = 2'd2;
    localparam logic [1:0] StDone    = 2'd3;

    function automatic logic [2:0] cnf_bytes(input logic [1:0] cnf);
        case (cnf)
            CnfByte: cnf_bytes = 3'd1;
            CnfHalf: cnf_bytes = 3'd2;
            default: cnf_bytes = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Fetch, MEM-stage and byte-wide RAM signals of the memory controller.
interface mem_ctrl_if;
    import mem_ctrl_pkg::*;

    logic                 if_req;
    logic [InstAddrW-1:0] if_addr;
    logic [InstW-1:0]     if_data;
    logic                 if_done;
    logic [InstAddrW-1:0] addr_mem;
    logic                 wr_mem;
    logic [InstW-1:0]     data_mem;
    logic [1:0]           cnf_mem;
    logic                 addr_needed;
    logic                 mem_working;
    logic                 mem_available;
    logic [InstW-1:0]     data_in;
    logic [RamDataW-1:0]  mem_din;
    logic [RamDataW-1:0]  mem_dout;
    logic [InstAddrW-1:0] mem_a;
    logic                 mem_wr;

    modport slave (
        input  if_req, if_addr, addr_mem, wr_mem, data_mem, cnf_mem, mem_din,
        output if_data, if_done, addr_needed, mem_working, mem_available, data_in,
        output mem_dout, mem_a, mem_wr
    );

    modport master (
        output if_req, if_addr, addr_mem, wr_mem, data_mem, cnf_mem, mem_din,
        input  if_data, if_done, addr_needed, mem_working, mem_available, data_in,
        input  mem_dout, mem_a, mem_wr
    );

endinterface

// File: rtl/mem_ctrl.sv
// Serialises instruction fetches and MEM-stage loads/stores onto a byte-wide RAM
// with one-cycle read latency; MEM requests take priority over fetches.
module mem_ctrl
    import mem_ctrl_pkg::*;
(
    input logic       clk,
    input logic       rst,
    mem_ctrl_if.slave bus
);

    logic [1:0]           state_q, state_d;
    logic [InstAddrW-1:0] base_q, base_d;
    logic [InstW-1:0]     wdata_q, wdata_d;
    logic [InstW-1:0]     result_q, result_d;
    logic                 wr_q, wr_d;
    logic                 is_mem_q, is_mem_d;
    logic [2:0]           n_q, n_d;
    logic [2:0]           cnt_q, cnt_d;

    logic                 busy, addr_phase, accept_mem;
    logic [2:0]           last_cnt;
    logic [1:0]           cap_idx;
    logic [InstW-1:0]     wshift;

    assign busy       = (state_q == StMemBusy) || (state_q == StIfBusy);
    assign addr_phase = busy && (cnt_q < n_q);
    assign accept_mem = (state_q == StIdle) && (bus.cnf_mem != CnfNone);
    // Loads need one extra cycle to collect the byte returned for the last address.
    assign last_cnt   = wr_q ? (n_q - 3'd1) : n_q;
    assign cap_idx    = 2'(cnt_q - 3'd1);
    assign wshift     = wdata_q >> {cnt_q[1:0], 3'b000};

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        wdata_d  = wdata_q;
        result_d = result_q;
        wr_d     = wr_q;
        is_mem_d = is_mem_q;
        n_d      = n_q;
        cnt_d    = cnt_q;
        case (state_q)
            StIdle: begin
                if (accept_mem) begin
                    state_d  = StMemBusy;
                    base_d   = bus.addr_mem;
                    wr_d     = bus.wr_mem;
                    wdata_d  = bus.data_mem;
                    n_d      = cnf_bytes(bus.cnf_mem);
                    is_mem_d = 1'b1;
                    cnt_d    = 3'd0;
                    result_d = '0;
                end else if (bus.if_req) begin
                    state_d  = StIfBusy;
                    base_d   = bus.if_addr;
                    wr_d     = 1'b0;
                    wdata_d  = '0;
                    n_d      = 3'd4;
                    is_mem_d = 1'b0;
                    cnt_d    = 3'd0;
                    result_d = '0;
                end
            end
            StMemBusy, StIfBusy: begin
                if (!wr_q && (cnt_q != 3'd0)) begin
                    result_d[{cap_idx, 3'b000} +: 8] = bus.mem_din;
                end
                if (cnt_q == last_cnt) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            base_q   <= '0;
            wdata_q  <= '0;
            result_q <= '0;
            wr_q     <= 1'b0;
            is_mem_q <= 1'b0;
            n_q      <= 3'd0;
            cnt_q    <= 3'd0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            wdata_q  <= wdata_d;
            result_q <= result_d;
            wr_q     <= wr_d;
            is_mem_q <= is_mem_d;
            n_q      <= n_d;
            cnt_q    <= cnt_d;
        end
    end

    // Every output is forced low while reset is held, even mid-transaction.
    assign bus.addr_needed   = !rst && (state_q == StIdle);
    assign bus.mem_working   = !rst && ((state_q == StMemBusy) || accept_mem);
    assign bus.mem_available = !rst && (state_q == StDone) && is_mem_q;
    assign bus.if_done       = !rst && (state_q == StDone) && !is_mem_q;
    assign bus.data_in       = bus.mem_available ? result_q : '0;
    assign bus.if_data       = bus.if_done ? result_q : '0;
    assign bus.mem_a         = (!rst && addr_phase) ? (base_q + {29'd0, cnt_q}) : '0;
    assign bus.mem_wr        = !rst && addr_phase && wr_q;
    assign bus.mem_dout      = bus.mem_wr ? wshift[7:0] : 8'd0;

endmodule
